// File: rtl/xy64_w32_combiner_if.sv
// Master-side request/acknowledge bus of the 32-bit to 64-bit X-side combiner.
//   master : the 32-bit bus master (drives address/data/enables/request)
//   slave  : the combiner (returns ack, read data and error)
// Signals: m_addr[31:0], m_wdata[31:0], m_be[3:0], m_rd, m_req (level, held
// until m_ack), m_ack (1-cycle), m_rdata[31:0], m_err (1-cycle, with m_ack).
interface xy64_w32_combiner_if;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_rd;
  logic        m_req;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;

  modport master (
    output m_addr, m_wdata, m_be, m_rd, m_req,
    input  m_ack, m_rdata, m_err
  );

  modport slave (
    input  m_addr, m_wdata, m_be, m_rd, m_req,
    output m_ack, m_rdata, m_err
  );
endinterface

// File: rtl/xy64_w32_combiner.sv
// Upstream feeder for the 64-bit X-side port. Converts 32-bit master requests
// into 64-bit X-side transactions, merging writes to the same 64-bit line in a
// one-entry write-combining buffer and lane-selecting read data on return.
// Ports:
//   ix_clk, ix_rst_n : clock, asynchronous active-low reset
//   m                : 32-bit master bus (slave modport)
//   flush            : level request to drain the buffer
//   empty            : buffer invalid and FSM idle
//   err_sticky       : a write drain saw x_err (cleared by reset only)
//   x_*              : 64-bit X-side request bus, wired straight to the bridge
//
// state      | meaning
// IDLE       | accept master requests, run the flush timer
// DRAIN      | waiting for !x_busy to issue the buffered write
// DRAIN_WAIT | write issued, waiting for x_ack
// RD_ISSUE   | waiting for !x_busy to issue the read
// RD_WAIT    | read issued, waiting for x_ack / x_err
// ACK        | m_ack (and m_err) visible this cycle
module xy64_w32_combiner #(
  parameter int FLUSH_CYCLES = 15,
  parameter int COMBINE      = 1
) (
  input  logic                   ix_clk,
  input  logic                   ix_rst_n,
  xy64_w32_combiner_if.slave     m,
  input  logic                   flush,
  output logic                   empty,
  output logic                   err_sticky,
  output logic [31:0]            x_addr,
  output logic [63:0]            x_wdata,
  output logic [7:0]             x_be,
  output logic                   x_rd,
  output logic                   x_req,
  input  logic [63:0]            x_rdata,
  input  logic                   x_busy,
  input  logic                   x_ack,
  input  logic                   x_err
);

  typedef enum logic [2:0] {IDLE, DRAIN, DRAIN_WAIT, RD_ISSUE, RD_WAIT, ACK} state_t;
  // Action to resume once a drain completes.
  typedef enum logic [1:0] {P_NONE, P_WR, P_ACK, P_RD} pend_t;

  state_t      state;
  pend_t       pend;
  logic        buf_valid;
  logic [28:0] buf_line;
  logic [63:0] buf_data;
  logic [7:0]  buf_be;
  logic [7:0]  flush_cnt;
  logic        x_req_q;

  logic [7:0]  wr_be64;
  logic [63:0] mrg_data;
  logic [7:0]  mrg_be;
  logic [63:0] new_data;
  logic        same_line;
  logic        idle_drain;
  logic        drain_done;
  logic [31:0] rd_lane;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^m.m_addr[1:0];

  assign wr_be64   = m.m_addr[2] ? {m.m_be, 4'h0} : {4'h0, m.m_be};
  assign same_line = (buf_line == m.m_addr[31:3]);
  assign rd_lane   = m.m_addr[2] ? x_rdata[63:32] : x_rdata[31:0];

  // mrg_* merges into the current buffer; new_* merges into an empty one
  // (used right after a drain, when buf_* still holds the drained line).
  always_comb begin
    mrg_data = buf_data;
    new_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (wr_be64[i]) begin
        mrg_data[8*i +: 8] = m.m_wdata[8*(i%4) +: 8];
        new_data[8*i +: 8] = m.m_wdata[8*(i%4) +: 8];
      end
    end
    mrg_be = buf_be | wr_be64;
  end

  assign idle_drain = buf_valid &&
                      (buf_be == 8'hFF || flush || flush_cnt == 8'(FLUSH_CYCLES));

  // x_req is gated combinationally by x_busy so it can never coincide with
  // busy, and by its own last value so it is never high two cycles running
  // (a drain completing with a same-cycle x_ack may go straight to another issue).
  assign x_req = (state == DRAIN || state == RD_ISSUE) && !x_busy && !x_req_q;

  assign drain_done = (state == DRAIN && x_req && x_ack) || (state == DRAIN_WAIT && x_ack);

  assign empty = !buf_valid && (state == IDLE);

  always_ff @(posedge ix_clk or negedge ix_rst_n) begin
    if (!ix_rst_n) begin
      state      <= IDLE;
      pend       <= P_NONE;
      buf_valid  <= 1'b0;
      buf_line   <= '0;
      buf_data   <= '0;
      buf_be     <= '0;
      flush_cnt  <= '0;
      x_req_q    <= 1'b0;
      x_addr     <= '0;
      x_wdata    <= '0;
      x_be       <= '0;
      x_rd       <= 1'b0;
      m.m_ack    <= 1'b0;
      m.m_err    <= 1'b0;
      m.m_rdata  <= '0;
      err_sticky <= 1'b0;
    end else begin
      x_req_q <= x_req;
      case (state)
        IDLE: begin
          if (m.m_req && !m.m_rd) begin
            flush_cnt <= '0;
            if (COMBINE != 0 && (!buf_valid || same_line)) begin
              buf_valid <= 1'b1;
              buf_line  <= m.m_addr[31:3];
              buf_data  <= mrg_data;
              buf_be    <= mrg_be;
              m.m_ack   <= 1'b1;
              state     <= ACK;
            end else if (buf_valid) begin
              x_addr  <= {buf_line, 3'b000};
              x_wdata <= buf_data;
              x_be    <= buf_be;
              x_rd    <= 1'b0;
              pend    <= P_WR;
              state   <= DRAIN;
            end else begin
              // Pass-through: load the write and drain it, ack after x_ack.
              buf_valid <= 1'b1;
              buf_line  <= m.m_addr[31:3];
              buf_data  <= new_data;
              buf_be    <= wr_be64;
              x_addr    <= {m.m_addr[31:3], 3'b000};
              x_wdata   <= new_data;
              x_be      <= wr_be64;
              x_rd      <= 1'b0;
              pend      <= P_ACK;
              state     <= DRAIN;
            end
          end else if (m.m_req) begin
            if (buf_valid) begin
              x_addr    <= {buf_line, 3'b000};
              x_wdata   <= buf_data;
              x_be      <= buf_be;
              x_rd      <= 1'b0;
              flush_cnt <= '0;
              pend      <= P_RD;
              state     <= DRAIN;
            end else begin
              x_addr  <= {m.m_addr[31:3], 3'b000};
              x_wdata <= '0;
              x_be    <= wr_be64;
              x_rd    <= 1'b1;
              state   <= RD_ISSUE;
            end
          end else if (idle_drain) begin
            x_addr    <= {buf_line, 3'b000};
            x_wdata   <= buf_data;
            x_be      <= buf_be;
            x_rd      <= 1'b0;
            flush_cnt <= '0;
            pend      <= P_NONE;
            state     <= DRAIN;
          end else if (buf_valid) begin
            flush_cnt <= flush_cnt + 8'd1;
          end
        end

        DRAIN, DRAIN_WAIT: begin
          if (x_err) err_sticky <= 1'b1;
          if (drain_done) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_be    <= '0;
            flush_cnt <= '0;
            pend      <= P_NONE;
            case (pend)
              P_WR: begin
                buf_valid <= 1'b1;
                buf_line  <= m.m_addr[31:3];
                buf_data  <= new_data;
                buf_be    <= wr_be64;
                if (COMBINE != 0) begin
                  m.m_ack <= 1'b1;
                  state   <= ACK;
                end else begin
                  x_addr  <= {m.m_addr[31:3], 3'b000};
                  x_wdata <= new_data;
                  x_be    <= wr_be64;
                  x_rd    <= 1'b0;
                  pend    <= P_ACK;
                  state   <= DRAIN;
                end
              end
              P_ACK: begin
                m.m_ack <= 1'b1;
                state   <= ACK;
              end
              P_RD: begin
                x_addr  <= {m.m_addr[31:3], 3'b000};
                x_wdata <= '0;
                x_be    <= wr_be64;
                x_rd    <= 1'b1;
                state   <= RD_ISSUE;
              end
              default: state <= IDLE;
            endcase
          end else if (x_req) begin
            state <= DRAIN_WAIT;
          end
        end

        RD_ISSUE: begin
          if (x_req) state <= RD_WAIT;
        end

        RD_WAIT: begin
          if (x_err) begin
            m.m_rdata <= '0;
            m.m_err   <= 1'b1;
            m.m_ack   <= 1'b1;
            state     <= ACK;
          end else if (x_ack) begin
            m.m_rdata <= rd_lane;
            m.m_ack   <= 1'b1;
            state     <= ACK;
          end
        end

        ACK: begin
          m.m_ack <= 1'b0;
          m.m_err <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xy64_w32_combiner.sv
// Directed bench for xy64_w32_combiner: one combining instance and one
// pass-through instance, each with a small bridge responder.
module tb_xy64_w32_combiner;
  logic ix_clk = 1'b0;
  logic ix_rst_n = 1'b0;
  always #5 ix_clk = ~ix_clk;

  int cyc = 0;
  always @(posedge ix_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        rd;
    int          cyc;
  } tx_t;

  // combining instance
  xy64_w32_combiner_if mif();
  logic        flush = 1'b0;
  logic        empty, err_sticky;
  logic [31:0] x_addr;
  logic [63:0] x_wdata;
  logic [7:0]  x_be;
  logic        x_rd, x_req;
  logic [63:0] x_rdata = '0;
  logic        x_busy = 1'b0;
  logic        x_ack = 1'b0;
  logic        x_err = 1'b0;

  xy64_w32_combiner #(.FLUSH_CYCLES(15), .COMBINE(1)) u_dut (
    .ix_clk(ix_clk), .ix_rst_n(ix_rst_n), .m(mif), .flush(flush),
    .empty(empty), .err_sticky(err_sticky),
    .x_addr(x_addr), .x_wdata(x_wdata), .x_be(x_be), .x_rd(x_rd), .x_req(x_req),
    .x_rdata(x_rdata), .x_busy(x_busy), .x_ack(x_ack), .x_err(x_err)
  );

  // pass-through instance
  xy64_w32_combiner_if mif_nc();
  logic        flush_nc = 1'b0;
  logic        empty_nc, err_sticky_nc;
  logic [31:0] x_addr_nc;
  logic [63:0] x_wdata_nc;
  logic [7:0]  x_be_nc;
  logic        x_rd_nc, x_req_nc;
  logic [63:0] x_rdata_nc = '0;
  logic        x_busy_nc = 1'b0;
  logic        x_ack_nc = 1'b0;
  logic        x_err_nc = 1'b0;

  xy64_w32_combiner #(.FLUSH_CYCLES(15), .COMBINE(0)) u_dut_nc (
    .ix_clk(ix_clk), .ix_rst_n(ix_rst_n), .m(mif_nc), .flush(flush_nc),
    .empty(empty_nc), .err_sticky(err_sticky_nc),
    .x_addr(x_addr_nc), .x_wdata(x_wdata_nc), .x_be(x_be_nc), .x_rd(x_rd_nc), .x_req(x_req_nc),
    .x_rdata(x_rdata_nc), .x_busy(x_busy_nc), .x_ack(x_ack_nc), .x_err(x_err_nc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bridge responder, main instance: ack (or err) 'lat' cycles after x_req
  int  lat = 1;
  bit  rd_err_mode = 0;
  bit  wr_err_mode = 0;
  int  pend = 0;
  bit  pend_rd = 0;
  bit  prev_req = 0;
  int  viol = 0;
  int  ack_cnt = 0;
  tx_t txq[$];

  task automatic respond(input bit r);
    if (r && rd_err_mode) x_err = 1'b1;
    else begin
      x_ack = 1'b1;
      x_err = !r && wr_err_mode;
    end
  endtask

  always @(negedge ix_clk) begin
    tx_t t;
    if (!ix_rst_n) begin
      pend = 0; x_ack = 1'b0; x_err = 1'b0; prev_req = 0;
    end else begin
      x_ack = 1'b0; x_err = 1'b0;
      if (mif.m_ack === 1'b1) ack_cnt++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) respond(pend_rd);
      end
      if (x_req === 1'b1) begin
        if (x_busy || prev_req) viol++;
        t.addr = x_addr; t.wdata = x_wdata; t.be = x_be; t.rd = x_rd; t.cyc = cyc;
        txq.push_back(t);
        if (lat == 0) respond(x_rd);
        else begin pend = lat; pend_rd = x_rd; end
      end
      prev_req = (x_req === 1'b1);
    end
  end

  // bridge responder, pass-through instance
  int  nc_lat = 1;
  int  nc_pend = 0;
  bit  prev_nc = 0;
  int  viol_nc = 0;
  tx_t nc_txq[$];

  always @(negedge ix_clk) begin
    tx_t t;
    if (!ix_rst_n) begin
      nc_pend = 0; x_ack_nc = 1'b0; prev_nc = 0;
    end else begin
      x_ack_nc = 1'b0;
      if (nc_pend > 0) begin
        nc_pend--;
        if (nc_pend == 0) x_ack_nc = 1'b1;
      end
      if (x_req_nc === 1'b1) begin
        if (x_busy_nc || prev_nc) viol_nc++;
        t.addr = x_addr_nc; t.wdata = x_wdata_nc; t.be = x_be_nc; t.rd = x_rd_nc; t.cyc = cyc;
        nc_txq.push_back(t);
        nc_pend = nc_lat;
      end
      prev_nc = (x_req_nc === 1'b1);
    end
  end

  task automatic m_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit rd, output logic [31:0] rdata, output logic err, output int ack_c);
    @(posedge ix_clk); #1;
    mif.m_addr = a; mif.m_wdata = d; mif.m_be = be; mif.m_rd = rd; mif.m_req = 1'b1;
    ack_c = -1; rdata = '0; err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ix_clk);
      if (mif.m_ack === 1'b1) begin
        ack_c = cyc; rdata = mif.m_rdata; err = mif.m_err;
        break;
      end
    end
    mif.m_req = 1'b0;
    chk("m_ack_seen", ack_c >= 0, 1);
  endtask

  task automatic m_xfer_nc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int ack_c;
    @(posedge ix_clk); #1;
    mif_nc.m_addr = a; mif_nc.m_wdata = d; mif_nc.m_be = be; mif_nc.m_rd = 1'b0; mif_nc.m_req = 1'b1;
    ack_c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ix_clk);
      if (mif_nc.m_ack === 1'b1) begin ack_c = cyc; break; end
    end
    mif_nc.m_req = 1'b0;
    chk("nc_m_ack_seen", ack_c >= 0, 1);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge ix_clk);
    chk(tag, txq.size() >= n, 1);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          ac, ac2, rel;

  initial begin
    mif.m_addr = '0; mif.m_wdata = '0; mif.m_be = '0; mif.m_rd = 1'b0; mif.m_req = 1'b0;
    mif_nc.m_addr = '0; mif_nc.m_wdata = '0; mif_nc.m_be = '0; mif_nc.m_rd = 1'b0; mif_nc.m_req = 1'b0;

    repeat (3) @(posedge ix_clk);
    #1;
    chk("rst_m_ack", mif.m_ack, 0);
    chk("rst_empty", empty, 1);
    chk("rst_x_req", x_req, 0);
    chk("rst_x_addr", x_addr, 0);
    chk("rst_err_sticky", err_sticky, 0);
    ix_rst_n = 1'b1;
    repeat (2) @(posedge ix_clk);

    // 1: two writes into one line merge into a single full-line drain
    lat = 1;
    m_xfer(32'h1000, 32'hAAAA5555, 4'hF, 0, rdata, err, ac);
    chk("t1_held", txq.size(), 0);
    m_xfer(32'h1004, 32'h12345678, 4'hF, 0, rdata, err, ac);
    wait_tx(1, 40, "t1_tx_seen");
    repeat (5) @(posedge ix_clk);
    chk("t1_ntx", txq.size(), 1);
    chk("t1_addr", txq[0].addr, 32'h1000);
    chk("t1_wdata", txq[0].wdata, 64'h12345678_AAAA5555);
    chk("t1_be", txq[0].be, 8'hFF);
    chk("t1_rd", txq[0].rd, 0);
    chk("t1_acks", ack_cnt, 2);
    chk("t1_empty", empty, 1);

    // 2: partial line flushed by the idle timer
    txq.delete();
    m_xfer(32'h2004, 32'h0000BEEF, 4'h3, 0, rdata, err, ac);
    wait_tx(1, 60, "t2_tx_seen");
    chk("t2_delay", txq[0].cyc - ac, 17);
    chk("t2_addr", txq[0].addr, 32'h2000);
    chk("t2_be", txq[0].be, 8'h30);
    chk("t2_wdata_hi", txq[0].wdata[47:32], 16'hBEEF);
    repeat (4) @(posedge ix_clk);

    // 3: write to another line drains the old line first
    lat = 2;
    txq.delete();
    m_xfer(32'h3000, 32'h33333333, 4'hF, 0, rdata, err, ac);
    m_xfer(32'h4000, 32'h00000044, 4'h1, 0, rdata, err, ac2);
    chk("t3_drain_before_ack", txq.size(), 1);
    chk("t3_drain_addr", txq[0].addr, 32'h3000);
    chk("t3_ack_after_drain", txq[0].cyc + 2 <= ac2, 1);
    wait_tx(2, 60, "t3_second_tx");
    chk("t3_held_addr", txq[1].addr, 32'h4000);
    chk("t3_held_be", txq[1].be, 8'h01);
    chk("t3_held_byte", txq[1].wdata[7:0], 8'h44);
    repeat (4) @(posedge ix_clk);

    // 4: read after buffered write; upper and lower lane select
    lat = 1;
    txq.delete();
    x_rdata = 64'h11112222_33334444;
    m_xfer(32'h5000, 32'h55667788, 4'hF, 0, rdata, err, ac);
    m_xfer(32'h5004, 32'h0, 4'hF, 1, rdata, err, ac);
    chk("t4_ntx", txq.size(), 2);
    chk("t4_wr_first", txq[0].rd, 0);
    chk("t4_wr_addr", txq[0].addr, 32'h5000);
    chk("t4_rd_second", txq[1].rd, 1);
    chk("t4_rd_addr", txq[1].addr, 32'h5000);
    chk("t4_rd_be", txq[1].be, 8'hF0);
    chk("t4_rdata_hi", rdata, 32'h11112222);
    chk("t4_no_err", err, 0);
    m_xfer(32'h5000, 32'h0, 4'h3, 1, rdata, err, ac);
    chk("t4_rd_be_lo", txq[2].be, 8'h03);
    chk("t4_rdata_lo", rdata, 32'h33334444);

    // 5: read held off by x_busy, completed by x_err
    txq.delete();
    rd_err_mode = 1;
    @(posedge ix_clk); #1;
    x_busy = 1'b1;
    fork
      m_xfer(32'h6000, 32'h0, 4'hF, 1, rdata, err, ac);
      begin
        repeat (6) @(posedge ix_clk);
        #1;
        x_busy = 1'b0;
        rel = cyc;
      end
    join
    chk("t5_ntx", txq.size(), 1);
    chk("t5_req_at_release", txq[0].cyc, rel);
    chk("t5_m_err", err, 1);
    chk("t5_rdata_zero", rdata, 0);
    rd_err_mode = 0;

    // flush level and sticky write error
    txq.delete();
    wr_err_mode = 1;
    m_xfer(32'h7000, 32'h00000077, 4'h1, 0, rdata, err, ac);
    @(posedge ix_clk); #1;
    flush = 1'b1;
    wait_tx(1, 20, "fl_tx_seen");
    repeat (5) @(posedge ix_clk);
    chk("fl_err_sticky", err_sticky, 1);
    chk("fl_empty", empty, 1);
    chk("fl_once", txq.size(), 1);
    wr_err_mode = 0;
    m_xfer(32'h7008, 32'hCAFEF00D, 4'hF, 0, rdata, err, ac);
    wait_tx(2, 20, "fl_second_tx");
    chk("fl_second_addr", txq[1].addr, 32'h7008);
    @(posedge ix_clk); #1;
    flush = 1'b0;

    // 6: pass-through instance, then reset during DRAIN_WAIT
    nc_lat = 1;
    m_xfer_nc(32'h8000, 32'h00000001, 4'hF);
    chk("t6_first_drained", nc_txq.size(), 1);
    m_xfer_nc(32'h8004, 32'h00000002, 4'hF);
    chk("t6_second_drained", nc_txq.size(), 2);
    chk("t6_second_addr", nc_txq[1].addr, 32'h8000);
    chk("t6_second_be", nc_txq[1].be, 8'hF0);
    chk("t6_second_wdata", nc_txq[1].wdata, 64'h00000002_00000000);
    nc_lat = 50;
    @(posedge ix_clk); #1;
    mif_nc.m_addr = 32'h9000; mif_nc.m_wdata = 32'h9; mif_nc.m_be = 4'hF; mif_nc.m_rd = 1'b0;
    mif_nc.m_req = 1'b1;
    for (int i = 0; i < 20 && nc_txq.size() < 3; i++) @(negedge ix_clk);
    chk("t6_third_issued", nc_txq.size(), 3);
    repeat (3) @(posedge ix_clk);
    #1;
    chk("t6_busy_before_rst", empty_nc, 0);
    ix_rst_n = 1'b0;
    #1;
    chk("t6_rst_m_ack", mif_nc.m_ack, 0);
    chk("t6_rst_empty", empty_nc, 1);
    chk("t6_rst_x_req", x_req_nc, 0);
    chk("t6_rst_x_addr", x_addr_nc, 0);
    chk("t6_rst_x_be", x_be_nc, 0);
    chk("t6_rst_x_wdata", x_wdata_nc, 0);
    chk("t6_rst_main_empty", empty, 1);
    mif_nc.m_req = 1'b0;
    repeat (2) @(posedge ix_clk);
    #1;
    ix_rst_n = 1'b1;
    repeat (10) @(posedge ix_clk);
    chk("t6_no_replay", nc_txq.size(), 3);
    chk("t6_empty_after", empty_nc, 1);

    chk("x_req_rules", viol, 0);
    chk("x_req_rules_nc", viol_nc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
